// File: rtl/cipher_pkg.sv
// Shared constants and types for the cipher core round sequencing logic.
package cipher_pkg;

    localparam int unsigned NUM_ROUNDS_DEF = 16;
    localparam int unsigned CNT_WIDTH_DEF  = 5;

    typedef logic [CNT_WIDTH_DEF-1:0] round_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        DONE
    } seq_state_t;

endpackage

// File: rtl/round_down_counter.sv
// Loadable down-counter that saturates at zero; flags when the count is one.
module round_down_counter #(
    parameter int unsigned Width = 5
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    input  logic             dec_en,
    output logic [Width-1:0] count,
    output logic             is_one
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec_en && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign is_one = (count_q == Width'(1));

endmodule

// File: rtl/round_down_sequencer.sv
// Decrypt-side round sequencer: walks round keys from NUM_ROUNDS down to 1,
// handshaking each round with the inverse-round datapath.
module round_down_sequencer
    import cipher_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = cipher_pkg::NUM_ROUNDS_DEF,
    parameter int unsigned CNT_WIDTH  = cipher_pkg::CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 round_ack,
    output logic                 round_valid,
    output logic [CNT_WIDTH-1:0] round_count,
    output logic [CNT_WIDTH-1:0] key_index,
    output logic                 first_round,
    output logic                 final_round,
    output logic                 busy,
    output logic                 done
);

    if (NUM_ROUNDS < 1) begin : g_bad_rounds
        $error("round_down_sequencer: NUM_ROUNDS must be at least 1");
    end
    if ((64'd1 << CNT_WIDTH) <= 64'(NUM_ROUNDS)) begin : g_bad_width
        $error("round_down_sequencer: CNT_WIDTH too narrow for NUM_ROUNDS");
    end

    seq_state_t state_d, state_q;

    logic                 cnt_load;
    logic [CNT_WIDTH-1:0] cnt_load_value;
    logic                 cnt_dec;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 cnt_is_one;

    round_down_counter #(
        .Width (CNT_WIDTH)
    ) u_counter (
        .clk        (clk),
        .n_rst      (n_rst),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec_en     (cnt_dec),
        .count      (cnt),
        .is_one     (cnt_is_one)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort overrides everything; clearing goes through the counter load path.
    always_comb begin
        state_d        = state_q;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_dec        = 1'b0;
        if (abort) begin
            state_d  = IDLE;
            cnt_load = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d        = LOAD;
                        cnt_load       = 1'b1;
                        cnt_load_value = CNT_WIDTH'(NUM_ROUNDS);
                    end
                end
                LOAD: state_d = ROUND;
                ROUND: begin
                    if (round_ack) begin
                        cnt_dec = 1'b1;
                        state_d = cnt_is_one ? DONE : LOAD;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        round_valid = (state_q == ROUND);
        busy        = (state_q == LOAD) || (state_q == ROUND);
        done        = (state_q == DONE);
        first_round = round_valid && (cnt == CNT_WIDTH'(NUM_ROUNDS));
        final_round = round_valid && cnt_is_one;
        round_count = cnt;
        key_index   = cnt;
    end

endmodule
